// File: rtl/store_rmw_pkg.sv
// Shared CPU store/load definitions: op encodings, RMW FSM states, request payload.
package store_rmw_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 2;

    typedef enum logic [OPW-1:0] {
        OP_SW  = 2'd0,
        OP_SH  = 2'd1,
        OP_SB  = 2'd2,
        OP_RSV = 2'd3
    } store_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_MERGE  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } rmw_state_e;

    typedef struct packed {
        store_op_e         op;
        logic [XLEN-1:0]   wdata;
    } store_req_t;

    // Reserved op, misaligned halfword or misaligned word is rejected.
    function automatic logic store_reject(input store_op_e op, input logic [1:0] offset);
        logic rej;
        case (op)
            OP_SW:   rej = (offset != 2'b00);
            OP_SH:   rej = offset[0];
            OP_SB:   rej = 1'b0;
            default: rej = 1'b1;
        endcase
        return rej;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Replaces the addressed byte/halfword lane of a RAM word with store data (little-endian).
module store_lane_merge
    import store_rmw_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  op,
    input  logic [1:0]  offset,
    output logic [31:0] new_word
);

    always_comb begin
        new_word = old_word;
        case (store_op_e'(op))
            OP_SB: begin
                case (offset)
                    2'd0:    new_word[7:0]   = wdata[7:0];
                    2'd1:    new_word[15:8]  = wdata[7:0];
                    2'd2:    new_word[23:16] = wdata[7:0];
                    default: new_word[31:24] = wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (offset[1]) new_word[31:16] = wdata[15:0];
                else           new_word[15:0]  = wdata[15:0];
            end
            OP_SW:   new_word = wdata;
            default: new_word = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw.sv
// Store unit: full-word stores write directly, byte/halfword stores do read-merge-write.
module store_rmw
    import store_rmw_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [31:0]   mem_rdata,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    output logic          done,
    output logic          err
);

    rmw_state_e    state, state_d;
    store_req_t    req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          reject_q, reject_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   merged_word;

    logic          ready_d, re_d, we_d, done_d, err_d;
    logic [AW-1:0] mem_addr_d;
    logic [31:0]   mem_wdata_d;

    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .wdata    (req_q.wdata),
        .op       (req_q.op),
        .offset   (addr_q[1:0]),
        .new_word (merged_word)
    );

    // Next state and next registered outputs, derived from the state being entered.
    always_comb begin
        state_d  = state;
        req_d    = req_q;
        addr_d   = addr_q;
        reject_d = reject_q;
        merge_d  = merge_q;

        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    req_d    = '{op: store_op_e'(req_op), wdata: req_wdata};
                    addr_d   = req_addr;
                    reject_d = store_reject(store_op_e'(req_op), req_addr[1:0]);
                    if (reject_d)                           state_d = ST_FINISH;
                    else if (store_op_e'(req_op) == OP_SW)  state_d = ST_WRITE;
                    else                                    state_d = ST_READ;
                end
            end
            ST_READ:   state_d = ST_MERGE;
            ST_MERGE: begin
                merge_d = merged_word;
                state_d = ST_WRITE;
            end
            ST_WRITE:  state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        re_d    = (state_d == ST_READ);
        we_d    = (state_d == ST_WRITE);
        done_d  = (state_d == ST_FINISH);
        err_d   = done_d && reject_d;

        mem_addr_d = '0;
        if (state_d == ST_READ || state_d == ST_MERGE || state_d == ST_WRITE)
            mem_addr_d = {addr_d[AW-1:2], 2'b00};

        mem_wdata_d = '0;
        if (we_d)
            mem_wdata_d = (req_d.op == OP_SW) ? req_d.wdata : merge_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            addr_q    <= '0;
            reject_q  <= 1'b0;
            merge_q   <= '0;
            req_ready <= 1'b1;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            reject_q  <= reject_d;
            merge_q   <= merge_d;
            req_ready <= ready_d;
            mem_re    <= re_d;
            mem_we    <= we_d;
            done      <= done_d;
            err       <= err_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_store_rmw.sv
// Directed bench for store_rmw with a RAM model and write/done scoreboards.
module tb_store_rmw;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    logic [31:0] ram [0:63];
    wr_t         exp_wr[$];
    logic        exp_done[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hs_count = 0;
    int hs_cyc = 0;
    int done_count = 0;
    int we_count = 0;
    logic [31:0] last_wr_data = 32'd0;

    store_rmw #(.AW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endfunction

    // Reference behaviour: mask-and-replicate lane update, reject rules, latency.
    function automatic void model(input logic [1:0] op, input logic [1:0] off,
                                  input logic [31:0] old, input logic [31:0] wd,
                                  output logic rej, output logic [31:0] nw, output int lat);
        logic [31:0] mask;
        logic [31:0] rep;
        rej = (op == 2'd3) || (op == 2'd1 && off[0]) || (op == 2'd0 && off != 2'd0);
        case (op)
            2'd0:    begin mask = 32'hffff_ffff; rep = wd; end
            2'd1:    begin mask = 32'h0000_ffff << (8 * off); rep = {2{wd[15:0]}}; end
            default: begin mask = 32'h0000_00ff << (8 * off); rep = {4{wd[7:0]}}; end
        endcase
        nw  = (old & ~mask) | (rep & mask);
        lat = rej ? 1 : ((op == 2'd0) ? 2 : 4);
    endfunction

    // RAM model plus handshake detection; expectations are pushed at each handshake.
    always @(posedge clk) begin
        logic        rej;
        logic [31:0] nw;
        int          lat;
        cyc <= cyc + 1;
        if (!rst && req_valid && req_ready) begin
            model(req_op, req_addr[1:0], ram[req_addr[7:2]], req_wdata, rej, nw, lat);
            if (!rej) exp_wr.push_back('{addr: {req_addr[31:2], 2'b00}, data: nw});
            exp_done.push_back(rej);
            hs_count <= hs_count + 1;
            hs_cyc   <= cyc;
        end
        if (mem_re) mem_rdata <= ram[mem_addr[7:2]];
        if (mem_we) ram[mem_addr[7:2]] = mem_wdata;
    end

    always @(negedge clk) begin
        wr_t  e;
        logic e_err;
        if (!rst) begin
            if (mem_we) begin
                we_count++;
                last_wr_data = mem_wdata;
                chk("we_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr_nore", 64'({mem_re, mem_addr}), 64'({1'b0, e.addr}));
                    chk("wr_data", 64'(mem_wdata), 64'(e.data));
                end
            end
            if (done) begin
                done_count++;
                chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
                if (exp_done.size() != 0) begin
                    e_err = exp_done.pop_front();
                    chk("done_err", 64'(err), 64'(e_err));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(req_ready), 64'd1);
    endtask

    // One store with cycle-exact checks of re/we/done/ready after the handshake.
    task automatic do_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
        logic        rej;
        logic [31:0] nw;
        int          lat;
        wait_ready();
        model(op, addr[1:0], ram[addr[7:2]], wd, rej, nw, lat);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            chk($sformatf("seq_op%0d_c%0d", op, c), 64'({mem_re, mem_we, done, req_ready}),
                64'({(lat == 4 && c == 1), (!rej && c == lat - 1), (c == lat), (c == lat + 1)}));
        end
    endtask

    initial begin
        int h0;
        int d0;
        int w0;
        int prev_cyc;
        logic [1:0] prev_op;

        for (int i = 0; i < 64; i++) ram[i] = 32'h0;

        #2 rst = 1'b1;
        #1;
        chk("reset_ctl", 64'({req_ready, mem_re, mem_we, done, err}), 64'(5'b10000));
        chk("reset_addr", 64'(mem_addr), 64'd0);
        chk("reset_wdata", 64'(mem_wdata), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full-word store
        do_store(2'd0, 32'h100, 32'h0000_a0f0);
        chk("sw_word", 64'(last_wr_data), 64'h0000_a0f0);

        // Byte and halfword merges into a known RAM word
        ram[0] = 32'h1122_3344;
        do_store(2'd2, 32'h101, 32'h0000_00f0);
        chk("sb_word", 64'(last_wr_data), 64'h1122_f044);
        ram[0] = 32'h1122_3344;
        do_store(2'd1, 32'h102, 32'h0000_a0f0);
        chk("sh_word", 64'(last_wr_data), 64'ha0f0_3344);

        ram[1] = 32'hdead_beef;
        do_store(2'd2, 32'h104, 32'hffff_ff5a);
        do_store(2'd2, 32'h106, 32'h0000_00c3);
        do_store(2'd2, 32'h107, 32'h1234_5699);
        chk("sb_lanes", 64'(last_wr_data), 64'h99c3_be5a);
        ram[2] = 32'h0bad_f00d;
        do_store(2'd1, 32'h108, 32'h7777_1357);
        do_store(2'd0, 32'h10c, $urandom);

        // Rejected requests
        w0 = we_count;
        do_store(2'd1, 32'h103, 32'h0000_a0f0);
        do_store(2'd3, 32'h100, 32'h5555_5555);
        do_store(2'd0, 32'h102, 32'h6666_6666);
        chk("reject_no_we", 64'(we_count), 64'(w0));

        // Reset during MERGE of a byte store
        wait_ready();
        d0 = done_count;
        w0 = we_count;
        req_valid = 1'b1; req_op = 2'd2; req_addr = 32'h111; req_wdata = 32'h0000_00aa;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_read", 64'(mem_re), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_merge_rst", 64'({req_ready, mem_re, mem_we, done, err}), 64'(5'b10000));
        exp_wr.delete();
        exp_done.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_merge_nodone", 64'(done_count), 64'(d0));
        chk("abort_merge_nowe", 64'(we_count), 64'(w0));
        do_store(2'd0, 32'h114, 32'hcafe_0001);
        chk("after_abort_sw", 64'(last_wr_data), 64'hcafe_0001);

        // Reset while WRITE is active drops mem_we at once
        wait_ready();
        d0 = done_count;
        req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h130; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_write_we", 64'(mem_we), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_write_rst", 64'({mem_we, done, req_ready}), 64'(3'b001));
        exp_done.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_write_nodone", 64'(done_count), 64'(d0));

        // req_valid held high with alternating SW/SB
        h0 = hs_count;
        d0 = done_count;
        prev_cyc = 0;
        prev_op = 2'd0;
        ram[8] = 32'h8765_4321;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h120; req_wdata = 32'h0101_0101;
        for (int i = 0; i < 6; i++) begin
            int n = 0;
            while (hs_count == h0 + i && n < 30) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("stream_hs_seen", 64'(hs_count - h0), 64'(i + 1));
            chk("stream_done_before", 64'(done_count - d0), 64'(i));
            if (i > 0)
                chk("stream_gap", 64'(hs_cyc - prev_cyc), (prev_op == 2'd0) ? 64'd3 : 64'd5);
            prev_cyc = hs_cyc;
            prev_op  = req_op;
            if (i == 5) begin
                req_valid = 1'b0;
            end else begin
                req_op    = (i % 2 == 0) ? 2'd2 : 2'd0;
                req_addr  = 32'h120 + 32'(i + 1);
                req_wdata = $urandom;
                if (req_op == 2'd0) req_addr = 32'h120;
            end
        end
        repeat (8) @(negedge clk);
        chk("stream_done_count", 64'(done_count - d0), 64'(hs_count - h0));
        chk("sb_queue_empty", 64'({exp_wr.size(), exp_done.size()}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
